// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared widths and pipeline stage type for the shared multiplier arbiter.
package mul_share_pkg;
    localparam int DW = 18;
    localparam int PW = 36;
    localparam int IDW_MAX = 3;
    typedef logic signed [DW-1:0] opnd_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef struct packed {
        logic               v;
        logic [IDW_MAX-1:0] id;
        prod_t              prod;
    } stage_t;
endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin pick starting at the pointer, one-hot grant gated by enable.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_v
);
    logic [IDW-1:0] ptr;
    // Scan downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        gnt_v  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                gnt_id = IDW'((int'(ptr) + k) % NREQ);
                gnt_v  = 1'b1;
            end
        end
        grant[gnt_id] = gnt_v && en;
    end
    always_ff @(posedge CLK) begin
        if (RST)
            ptr <= '0;
        else if (en && gnt_v)
            ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
endmodule

// File: rtl/multiplier.sv
// multiplier: combinational full-precision 18x18 signed multiply.
module multiplier
    import mul_share_pkg::*;
(
    input  opnd_t a,
    input  opnd_t b,
    output prod_t p
);
    assign p = a * b;
endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one 18x18 signed multiplier with an ID-tagged,
// backpressured response port.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PIPE = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output prod_t              rsp_p,
    output logic               busy,
    output logic [31:0]        op_count
);
    logic           adv;
    logic           gnt_v;
    logic [IDW-1:0] gnt_id;
    logic           v0;
    logic [IDW-1:0] id0;
    opnd_t          a0;
    opnd_t          b0;
    prod_t          prod;
    stage_t         st [1:PIPE];

    // A held response freezes the whole pipe, so no grant is issued while stalled.
    assign adv       = !(rsp_valid && !rsp_ready);
    assign rsp_valid = st[PIPE].v;
    assign rsp_id    = st[PIPE].id[IDW-1:0];
    assign rsp_p     = st[PIPE].prod;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .en     (adv),
        .req    (req_valid),
        .grant  (req_ready),
        .gnt_id (gnt_id),
        .gnt_v  (gnt_v)
    );

    multiplier u_mul (
        .a (a0),
        .b (b0),
        .p (prod)
    );

    always_comb begin
        busy = v0;
        for (int j = 1; j <= PIPE; j++)
            busy = busy | st[j].v;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v0       <= 1'b0;
            id0      <= '0;
            a0       <= '0;
            b0       <= '0;
            op_count <= '0;
            for (int j = 1; j <= PIPE; j++)
                st[j] <= '0;
        end else begin
            if (adv) begin
                v0    <= gnt_v;
                id0   <= gnt_id;
                a0    <= gnt_v ? opnd_t'(req_a[gnt_id*DW +: DW]) : '0;
                b0    <= gnt_v ? opnd_t'(req_b[gnt_id*DW +: DW]) : '0;
                st[1] <= '{v: v0, id: IDW_MAX'(id0), prod: prod};
                for (int j = 2; j <= PIPE; j++)
                    st[j] <= st[j-1];
            end
            if (rsp_valid && rsp_ready && op_count != '1)
                op_count <= op_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed stimulus with a queue-based scoreboard and round-robin model.
module tb_mul_share_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*18-1:0]   req_a = '0;
    logic [N*18-1:0]   req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic signed [35:0] rsp_p;
    logic              busy;
    logic [31:0]       op_count;

    mul_share_arbiter #(.NREQ(N), .PIPE(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 CLK = ~CLK;

    typedef struct { int id; longint p; } rsp_t;

    int     tests = 0;
    int     fails = 0;
    int     qa [N][$];
    int     qb [N][$];
    rsp_t   exp_q [$];
    rsp_t   rlog [$];
    int     glog [$];
    int     ptr = 0;
    longint cnt_m = 0;
    logic   held = 1'b0;
    longint h_id;
    longint h_p;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int p, input int a, input int b);
        qa[p].push_back(a);
        qb[p].push_back(b);
    endtask

    function automatic logic idle();
        logic r;
        r = (exp_q.size() == 0) && !rsp_valid;
        for (int i = 0; i < N; i++)
            if (qa[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input string name);
        int n;
        for (n = 0; n < 300 && !idle(); n++) begin
            @(negedge CLK);
            #1;
        end
        chk(name, longint'(n < 300), 1);
    endtask

    task automatic reset_pulse();
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    // Requesters: hold each operand pair until it is accepted, then present the next one.
    initial begin
        logic [N-1:0] hs;
        forever begin
            @(negedge CLK);
            hs = req_valid & req_ready & {N{!RST}};
            @(posedge CLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    void'(qa[i].pop_front());
                    void'(qb[i].pop_front());
                end
                req_valid[i]     = qa[i].size() > 0;
                req_a[18*i +: 18] = req_valid[i] ? 18'(qa[i][0]) : 18'd0;
                req_b[18*i +: 18] = req_valid[i] ? 18'(qb[i][0]) : 18'd0;
            end
        end
    end

    // Reference: round-robin grant rule, in-order product queue, saturating response count.
    always @(negedge CLK) begin : cmp
        logic [N-1:0] er;
        logic         f;
        int           g;
        if (RST) begin
            exp_q.delete();
            ptr   = 0;
            cnt_m = 0;
            held  = 1'b0;
        end else begin
            chk("busy", longint'(busy), longint'(exp_q.size() != 0));
            chk("op_count", longint'(op_count), cnt_m);
            if (held) begin
                chk("hold_id", longint'(rsp_id), h_id);
                chk("hold_p", rsp_p, h_p);
            end
            held = rsp_valid && !rsp_ready;
            h_id = longint'(rsp_id);
            h_p  = rsp_p;
            if (rsp_valid) begin
                if (exp_q.size() == 0)
                    chk("spurious_rsp", 1, 0);
                else begin
                    chk("rsp_id", longint'(rsp_id), longint'(exp_q[0].id));
                    chk("rsp_p", rsp_p, exp_q[0].p);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        rlog.push_back('{int'(rsp_id), longint'(rsp_p)});
                        if (cnt_m < 64'hFFFF_FFFF) cnt_m++;
                    end
                end
            end
            er = '0;
            f  = 1'b0;
            g  = 0;
            if (!(rsp_valid && !rsp_ready))
                for (int k = 0; k < N; k++)
                    if (!f && req_valid[(ptr + k) % N]) begin
                        f = 1'b1;
                        g = (ptr + k) % N;
                        er[g] = 1'b1;
                    end
            chk("req_ready", longint'(req_ready), longint'(er));
            if (f) begin
                exp_q.push_back('{g, longint'($signed(req_a[18*g +: 18])) *
                                     longint'($signed(req_b[18*g +: 18]))});
                glog.push_back(g);
                ptr = (g + 1) % N;
            end
        end
    end

    initial begin
        int     n;
        int     lat;
        longint bp_p [8];
        bp_p = '{-2, 700, -6, 707, -12, 714, -20, 721};

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK); #1;
        chk("rst_rsp_valid", longint'(rsp_valid), 0);
        chk("rst_rsp_id", longint'(rsp_id), 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_op_count", longint'(op_count), 0);
        chk("rst_req_ready", longint'(req_ready), 0);

        // Single request: three cycles from the grant cycle to the response.
        push(0, 3, -5);
        @(negedge CLK); #1;
        for (n = 0; n < 20 && !req_ready[0]; n++) begin
            @(negedge CLK); #1;
        end
        chk("single_grant_seen", longint'(n < 20), 1);
        lat = 0;
        do begin
            @(negedge CLK); #1;
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("single_latency", lat, 3);
        chk("single_id", longint'(rsp_id), 0);
        chk("single_p", rsp_p, -15);
        drain("single_drain");

        // Arithmetic corners.
        rlog.delete();
        push(0, -131072, -131072);
        push(0, -131072, 131071);
        push(0, 0, -7);
        drain("corner_drain");
        chk("corner_count", rlog.size(), 3);
        if (rlog.size() == 3) begin
            chk("corner_min_min", rlog[0].p, 64'sd17179869184);
            chk("corner_min_max", rlog[1].p, -64'sd17179738112);
            chk("corner_zero", rlog[2].p, 0);
        end

        // Fairness: all ports requesting back-to-back from pointer 0.
        reset_pulse();
        rlog.delete();
        glog.delete();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                push(i, i + 1, k + 10);
        drain("fair_drain");
        chk("fair_grants", glog.size(), 8);
        chk("fair_rsps", rlog.size(), 8);
        if (glog.size() == 8 && rlog.size() == 8)
            for (int k = 0; k < 8; k++) begin
                chk("fair_grant_order", glog[k], k % 4);
                chk("fair_rsp_id", rlog[k].id, k % 4);
            end

        // Backpressure: stall the consumer for five cycles mid-stream.
        reset_pulse();
        rlog.delete();
        for (int k = 0; k < 4; k++) begin
            push(0, k + 1, -(k + 2));
            push(2, 100 + k, 7);
        end
        for (n = 0; n < 50 && rlog.size() < 2; n++) begin
            @(negedge CLK); #1;
        end
        chk("bp_started", longint'(n < 50), 1);
        @(posedge CLK); #1 rsp_ready = 1'b0;
        repeat (5) begin
            @(negedge CLK); #1;
            chk("bp_stall_ready", longint'(req_ready), 0);
            chk("bp_stall_valid", longint'(rsp_valid), 1);
        end
        @(posedge CLK); #1 rsp_ready = 1'b1;
        drain("bp_drain");
        chk("bp_count", rlog.size(), 8);
        if (rlog.size() == 8)
            for (int k = 0; k < 8; k++)
                chk("bp_order", rlog[k].p, bp_p[k]);
        chk("bp_op_count", longint'(op_count), 8);

        // Reset with three operations in flight.
        reset_pulse();
        glog.delete();
        push(1, 1, 1);
        push(2, 2, 2);
        push(2, 3, 3);
        push(3, 4, 4);
        push(3, 5, 5);
        for (n = 0; n < 50 && glog.size() < 3; n++) begin
            @(negedge CLK); #1;
        end
        chk("mid_three_grants", longint'(n < 50), 1);
        reset_pulse();
        @(negedge CLK); #1;
        chk("mid_rsp_valid", longint'(rsp_valid), 0);
        chk("mid_busy", longint'(busy), 0);
        chk("mid_op_count", longint'(op_count), 0);
        for (n = 0; n < 50 && glog.size() < 4; n++) begin
            @(negedge CLK); #1;
        end
        chk("mid_regrant_seen", longint'(glog.size() >= 4), 1);
        if (glog.size() >= 4)
            chk("mid_regrant_port", glog[3], 2);
        drain("mid_drain");

        // Sparse requests: pointer moves past port2, so port3 beats port1.
        reset_pulse();
        glog.delete();
        push(2, 6, 6);
        drain("sparse_drain1");
        push(1, 7, 7);
        push(3, 8, 8);
        drain("sparse_drain2");
        chk("sparse_count", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("sparse_g0", glog[0], 2);
            chk("sparse_g1", glog[1], 3);
            chk("sparse_g2", glog[2], 1);
        end
        chk("final_op_count", longint'(op_count), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
